// File: rtl/obstacle_pkg.sv
// obstacle_pkg
// Shared definitions for the obstacle subsystem: obstacle kind codes (also
// consumed by the obstacle instances), the scheduler state encoding, the
// scrolled-distance width and the rand-nibble to kind mapping.
package obstacle_pkg;

    localparam int unsigned DIST_W = 10;

    typedef enum logic [3:0] {
        KIND_NONE  = 4'd0,
        KIND_S_1   = 4'd1,
        KIND_B_1   = 4'd7,
        KIND_CL    = 4'd11,
        KIND_BD    = 4'd12,
        KIND_UNSET = 4'd15
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } sched_state_e;

    // 0..3 bird, 4..6 cluster, 7..9 small tree, 10..12 big tree, 13..15 empty
    function automatic kind_e kind_from_rand(input logic [3:0] r);
        kind_e k;
        if (r >= 4'd13)      k = KIND_NONE;
        else if (r >= 4'd10) k = KIND_B_1;
        else if (r >= 4'd7)  k = KIND_S_1;
        else if (r >= 4'd4)  k = KIND_CL;
        else                 k = KIND_BD;
        return k;
    endfunction

endpackage

// File: rtl/obstacle_scheduler_rr_free_pick.sv
// rr_free_pick
// Combinational round-robin picker: grants the first free slot found at or
// after rr_ptr, wrapping around the slot range.
// Ports:
//   slot_busy  in   NUM_SLOTS        slot currently on screen
//   rr_ptr     in   clog2(NUM_SLOTS) search start position
//   grant      out  NUM_SLOTS        one-hot chosen slot (0 when none free)
//   any_free   out  1                at least one slot is free
module rr_free_pick #(
    parameter int unsigned NUM_SLOTS = 2
) (
    input  logic [NUM_SLOTS-1:0]         slot_busy,
    input  logic [$clog2(NUM_SLOTS)-1:0] rr_ptr,
    output logic [NUM_SLOTS-1:0]         grant,
    output logic                         any_free
);

    localparam int unsigned PTR_W = $clog2(NUM_SLOTS);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        idx      = '0;
        any_free = ~&slot_busy;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            idx = PTR_W'((32'(rr_ptr) + i) % NUM_SLOTS);
            if (!found && !slot_busy[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
// Central spawn controller: accumulates scrolled distance per frame tick,
// enforces a randomized minimum gap, picks the obstacle kind from the LFSR
// word and pulses free slots in round-robin order. Owns the scroll speed
// and its difficulty ramp.
// Optional feature: define OBST_SPEED_RAMP_EN to enable the speed/level ramp;
// otherwise speed is fixed at SPEED_INIT and level at 0.
// Ports:
//   clk_25MHz  in   1          system clock
//   rst        in   1          synchronous active-high reset
//   tick       in   1          one-cycle frame strobe
//   rand_word  in   32         free-running LFSR word ("rand" is reserved)
//   start      in   1          begin/restart a run (level)
//   stop       in   1          freeze the run (level)
//   slot_busy  in   NUM_SLOTS  slot currently on screen
//   spawn      out  NUM_SLOTS  one-hot one-cycle spawn pulse
//   spawn_kind out  4          kind code, held until next spawn
//   speed      out  4          current scroll speed
//   level      out  4          ramp steps taken
//   running    out  1          high in RUN
module obstacle_scheduler #(
    parameter int NUM_SLOTS  = 2,
    parameter int MIN_GAP    = 200,
    parameter int SPEED_INIT = 3,
    parameter int SPEED_MAX  = 8,
    parameter int RAMP_TICKS = 1000
) (
    input  logic                 clk_25MHz,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [31:0]          rand_word,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    output logic [NUM_SLOTS-1:0] spawn,
    output logic [3:0]           spawn_kind,
    output logic [3:0]           speed,
    output logic [3:0]           level,
    output logic                 running
);

    import obstacle_pkg::*;

    localparam int unsigned PTR_W = $clog2(NUM_SLOTS);
    localparam logic [DIST_W-1:0] GAP_INIT     = DIST_W'(MIN_GAP);
    localparam logic [3:0]        SPEED_INIT_L = 4'(SPEED_INIT);

    if (NUM_SLOTS < 2 || NUM_SLOTS > 8 || RAMP_TICKS < 1 ||
        SPEED_MAX < SPEED_INIT || SPEED_MAX > 15 || MIN_GAP + 127 > 1023) begin : g_bad_cfg
        $error("obstacle_scheduler: unsupported parameter set");
    end

    sched_state_e          state_q, state_d;
    logic [DIST_W-1:0]     dist_q, dist_d;
    logic [DIST_W-1:0]     gap_q, gap_d;
    logic [3:0]            speed_q, speed_d;
    logic [3:0]            level_q, level_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_SLOTS-1:0]  spawn_q, spawn_d;
    logic [3:0]            kind_q, kind_d;

`ifdef OBST_SPEED_RAMP_EN
    localparam int unsigned RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST   = RAMP_W'(RAMP_TICKS - 1);
    localparam logic [3:0]        SPEED_MAX_L = 4'(SPEED_MAX);
    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
`endif

    logic [NUM_SLOTS-1:0] grant;
    logic                 any_free;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     ptr_next;
    logic [DIST_W:0]      dist_sum;
    logic [DIST_W-1:0]    dist_n;
    logic [DIST_W-1:0]    new_gap;
    kind_e                pick_kind;
    logic                 rand_unused;

    assign rand_unused = ^rand_word[31:11];

    rr_free_pick #(
        .NUM_SLOTS(NUM_SLOTS)
    ) u_pick (
        .slot_busy(slot_busy),
        .rr_ptr   (rr_ptr_q),
        .grant    (grant),
        .any_free (any_free)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
        ptr_next = (grant_idx == PTR_W'(NUM_SLOTS - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Saturating distance: the sum carries at most one bit past DIST_W.
    assign dist_sum  = {1'b0, dist_q} + (DIST_W + 1)'(speed_q);
    assign dist_n    = dist_sum[DIST_W] ? '1 : dist_sum[DIST_W-1:0];
    assign new_gap   = GAP_INIT + DIST_W'(rand_word[10:4]);
    assign pick_kind = kind_from_rand(rand_word[3:0]);

    always_comb begin
        state_d  = state_q;
        dist_d   = dist_q;
        gap_d    = gap_q;
        speed_d  = speed_q;
        level_d  = level_q;
        rr_ptr_d = rr_ptr_q;
        spawn_d  = '0;
        kind_d   = kind_q;
`ifdef OBST_SPEED_RAMP_EN
        ramp_cnt_d = ramp_cnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d  = ST_RUN;
                    dist_d   = '0;
                    gap_d    = GAP_INIT;
                    speed_d  = SPEED_INIT_L;
                    level_d  = '0;
                    rr_ptr_d = '0;
`ifdef OBST_SPEED_RAMP_EN
                    ramp_cnt_d = '0;
`endif
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_HALT;
                end else if (tick) begin
`ifdef OBST_SPEED_RAMP_EN
                    if (ramp_cnt_q == RAMP_LAST) begin
                        ramp_cnt_d = '0;
                        if (speed_q < SPEED_MAX_L) speed_d = speed_q + 4'd1;
                        if (level_q != 4'hF)       level_d = level_q + 4'd1;
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + 1'b1;
                    end
`endif
                    dist_d = dist_n;
                    if (dist_n >= gap_q) begin
                        if (pick_kind == KIND_NONE) begin
                            dist_d = '0;
                            gap_d  = new_gap;
                        end else if (any_free) begin
                            spawn_d  = grant;
                            kind_d   = pick_kind;
                            rr_ptr_d = ptr_next;
                            dist_d   = '0;
                            gap_d    = new_gap;
                        end
                        // all slots busy: keep the saturated distance and
                        // retry on the next tick with a fresh rand word
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dist_q   <= '0;
            gap_q    <= GAP_INIT;
            speed_q  <= SPEED_INIT_L;
            level_q  <= '0;
            rr_ptr_q <= '0;
            spawn_q  <= '0;
            kind_q   <= KIND_NONE;
`ifdef OBST_SPEED_RAMP_EN
            ramp_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            dist_q   <= dist_d;
            gap_q    <= gap_d;
            speed_q  <= speed_d;
            level_q  <= level_d;
            rr_ptr_q <= rr_ptr_d;
            spawn_q  <= spawn_d;
            kind_q   <= kind_d;
`ifdef OBST_SPEED_RAMP_EN
            ramp_cnt_q <= ramp_cnt_d;
`endif
        end
    end

    assign spawn      = spawn_q;
    assign spawn_kind = kind_q;
    assign speed      = speed_q;
    assign level      = level_q;
    assign running    = (state_q == ST_RUN);

endmodule
